// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and staggered per-domain reset release with filtered loss-of-lock re-assertion.
// Optional PLL kick watchdog is built when PLL_RESET_WATCHDOG_EN is defined.
module pll_reset_sequencer #(
  parameter int STABLE_CYCLES   = 1024,
  parameter int NUM_DOMAINS     = 3,
  parameter int STAGGER_CYCLES  = 16,
  parameter int LOCK_FILTER     = 4,
  parameter int WATCHDOG_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pll_locked,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic [7:0]             loss_count,
  output logic [1:0]             state,
  output logic                   pll_resetb
);

  localparam int IDX_W = 4;
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || STAGGER_CYCLES < 1 || STABLE_CYCLES < 1 ||
      LOCK_FILTER < 1 || WATCHDOG_CYCLES < 1) begin : g_param_check
    $error("pll_reset_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABILIZE = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic sync1_q;
  logic lock_s_q;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       lowcnt_q, lowcnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [7:0]             loss_q, loss_d;

  // pll_locked has no relation to clock; only lock_s_q may feed decisions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_WAIT_LOCK;
      cnt_q    <= '0;
      lowcnt_q <= '0;
      idx_q    <= '0;
      rst_q    <= '1;
      ready_q  <= 1'b0;
      loss_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lowcnt_q <= lowcnt_d;
      idx_q    <= idx_d;
      rst_q    <= rst_d;
      ready_q  <= ready_d;
      loss_q   <= loss_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lowcnt_d = lowcnt_q;
    idx_d    = idx_q;
    rst_d    = rst_q;
    ready_d  = ready_q;
    loss_d   = loss_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end
      end

      ST_STABILIZE: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_d    = '0;
          lowcnt_d = '0;
          rst_d[0] = 1'b0;
          if (NUM_DOMAINS == 1) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
            idx_d   = IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        // RELEASE and RUN: the loss filter outranks any pending release step.
        if (!lock_s_q && lowcnt_q == FILTER_LAST) begin
          state_d  = ST_WAIT_LOCK;
          rst_d    = '1;
          ready_d  = 1'b0;
          cnt_d    = '0;
          lowcnt_d = '0;
          idx_d    = '0;
          loss_d   = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end else begin
          lowcnt_d = lock_s_q ? '0 : lowcnt_q + 1'b1;
          if (state_q == ST_RELEASE) begin
            if (cnt_q == STAGGER_LAST) begin
              cnt_d = '0;
              idx_d = idx_q + 1'b1;
              for (int i = 0; i < NUM_DOMAINS; i++) begin
                if (idx_q == IDX_W'(i)) rst_d[i] = 1'b0;
              end
              if (idx_q == IDX_LAST) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign rst_out    = rst_q;
  assign ready      = ready_q;
  assign loss_count = loss_q;
  assign state      = state_q;

`ifdef PLL_RESET_WATCHDOG_EN
  // Only useful while the PLL still oscillates unlocked; a dead reference stops clock too.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [3:0]       pulse_cnt_q, pulse_cnt_d;
  logic             pulse_q, pulse_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt_q    <= '0;
      pulse_cnt_q <= 4'd0;
      pulse_q     <= 1'b0;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      pulse_q     <= pulse_d;
    end
  end

  always_comb begin
    wd_cnt_d    = '0;
    pulse_cnt_d = 4'd0;
    pulse_d     = 1'b0;
    if (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK) begin
      pulse_cnt_d = pulse_cnt_q;
      pulse_d     = pulse_q;
      if (wd_cnt_q == WD_LAST) begin
        wd_cnt_d    = '0;
        pulse_d     = 1'b1;
        pulse_cnt_d = 4'd0;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (pulse_q) begin
          if (pulse_cnt_q == 4'd15) pulse_d = 1'b0;
          else pulse_cnt_d = pulse_cnt_q + 4'd1;
        end
      end
    end
  end

  assign pll_resetb = ~pulse_q;
`else
  assign pll_resetb = 1'b1;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: directed lock stimulus, expected output changes queued
// with their cycle numbers and matched by an independent monitor.
module tb_pll_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic [2:0] rst_out;
  logic       ready;
  logic [7:0] loss_count;
  logic [1:0] state;
  logic       pll_resetb;

  pll_reset_sequencer #(
    .STABLE_CYCLES(8), .NUM_DOMAINS(3), .STAGGER_CYCLES(4),
    .LOCK_FILTER(4), .WATCHDOG_CYCLES(32), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .rst_out(rst_out), .ready(ready), .loss_count(loss_count),
    .state(state), .pll_resetb(pll_resetb)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int unsigned cyc;
    logic [2:0]  rst;
    logic        rdy;
    logic [7:0]  lc;
    logic [1:0]  st;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  bit          mon_en = 1'b0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic push(input int unsigned c, input logic [2:0] r, input logic rd,
                      input logic [7:0] lc, input logic [1:0] st);
    exp_t e;
    e.cyc = c; e.rst = r; e.rdy = rd; e.lc = lc; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, req);
    end else begin
      $display("ok   %s cyc=%0d value=%h", name, cyc, got);
    end
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clock);
  endtask

  // Monitor: every change of the observable outputs must match the head of the queue.
  initial begin
    logic [13:0] prev_obs;
    logic [13:0] obs;
    exp_t        e;
    prev_obs = '0;
    forever begin
      @(negedge clock);
      obs = {rst_out, ready, loss_count, state};
      if (mon_en && obs != prev_obs) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_change cyc=%0d got rst=%b rdy=%b lc=%0d st=%0d required no change",
                   cyc, rst_out, ready, loss_count, state);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.rst !== rst_out || e.rdy !== ready ||
              e.lc !== loss_count || e.st !== state) begin
            n_miss++;
            $display("FAIL step got cyc=%0d rst=%b rdy=%b lc=%0d st=%0d required cyc=%0d rst=%b rdy=%b lc=%0d st=%0d",
                     cyc, rst_out, ready, loss_count, state, e.cyc, e.rst, e.rdy, e.lc, e.st);
          end else begin
            $display("ok   step cyc=%0d rst=%b rdy=%b lc=%0d st=%0d", cyc, rst_out, ready, loss_count, state);
          end
        end
      end
      prev_obs = obs;
    end
  end

  initial begin
    int unsigned t;
    int unsigned d;
    int unsigned r;
    int          first_start;
    int          last_start;
    int          low_len;
    logic        prev_b;

    reset = 1'b1;
    pll_locked = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state", 32'({rst_out, ready, loss_count, state}), 32'({3'b111, 1'b0, 8'd0, 2'd0}));
    check("reset_pll_resetb", 32'(pll_resetb), 32'd1);
    mon_en = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Release sequence from first lock.
    pll_locked = 1'b1;
    t = cyc + 1;
    push(t + 2,  3'b111, 1'b0, 8'd0, 2'd1);
    push(t + 10, 3'b110, 1'b0, 8'd0, 2'd2);
    push(t + 14, 3'b100, 1'b0, 8'd0, 2'd2);
    push(t + 18, 3'b000, 1'b1, 8'd0, 2'd3);
    wait_cyc(t + 22);

    // Three-cycle glitch in RUN is filtered out.
    pll_locked = 1'b0;
    repeat (3) @(negedge clock);
    pll_locked = 1'b1;
    repeat (10) @(negedge clock);
    check("glitch_hold", 32'({rst_out, ready, loss_count, state}), 32'({3'b000, 1'b1, 8'd0, 2'd3}));

    // Filtered loss, then relock with identical offsets.
    pll_locked = 1'b0;
    d = cyc + 1;
    push(d + 5, 3'b111, 1'b0, 8'd1, 2'd0);
    repeat (8) @(negedge clock);
    pll_locked = 1'b1;
    t = cyc + 1;
    push(t + 2,  3'b111, 1'b0, 8'd1, 2'd1);
    push(t + 10, 3'b110, 1'b0, 8'd1, 2'd2);
    push(t + 14, 3'b100, 1'b0, 8'd1, 2'd2);
    push(t + 18, 3'b000, 1'b1, 8'd1, 2'd3);
    wait_cyc(t + 22);

    // Second loss, then a one-cycle drop during STABILIZE.
    pll_locked = 1'b0;
    d = cyc + 1;
    push(d + 5, 3'b111, 1'b0, 8'd2, 2'd0);
    repeat (8) @(negedge clock);
    pll_locked = 1'b1;
    t = cyc + 1;
    push(t + 2,  3'b111, 1'b0, 8'd2, 2'd1);
    push(t + 7,  3'b111, 1'b0, 8'd2, 2'd0);
    push(t + 8,  3'b111, 1'b0, 8'd2, 2'd1);
    push(t + 16, 3'b110, 1'b0, 8'd2, 2'd2);
    push(t + 20, 3'b100, 1'b0, 8'd2, 2'd2);
    push(t + 24, 3'b000, 1'b1, 8'd2, 2'd3);
    wait_cyc(t + 4);
    pll_locked = 1'b0;
    @(negedge clock);
    pll_locked = 1'b1;
    wait_cyc(t + 28);

    // Third loss, relock, then asynchronous reset after the first release.
    pll_locked = 1'b0;
    d = cyc + 1;
    push(d + 5, 3'b111, 1'b0, 8'd3, 2'd0);
    repeat (8) @(negedge clock);
    pll_locked = 1'b1;
    t = cyc + 1;
    push(t + 2,  3'b111, 1'b0, 8'd3, 2'd1);
    push(t + 10, 3'b110, 1'b0, 8'd3, 2'd2);
    wait_cyc(t + 10);
    @(posedge clock);
    #1;
    push(cyc, 3'b111, 1'b0, 8'd0, 2'd0);
    reset = 1'b1;
    #1;
    check("async_reset", 32'({rst_out, ready, loss_count, state}), 32'({3'b111, 1'b0, 8'd0, 2'd0}));
    pll_locked = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    r = cyc;

    // pll_resetb while lock is held low.
    first_start = -1;
    last_start  = -1;
    low_len     = 0;
    prev_b      = 1'b1;
    repeat (100) begin
      @(negedge clock);
`ifdef PLL_RESET_WATCHDOG_EN
      if (prev_b && !pll_resetb) begin
        if (first_start < 0) begin
          first_start = int'(cyc - r);
          check("wd_first_start", 32'(first_start), 32'd32);
        end else begin
          check("wd_period", 32'(int'(cyc - r) - last_start), 32'd32);
        end
        last_start = int'(cyc - r);
        low_len = 0;
      end
      if (!pll_resetb) low_len++;
      if (!prev_b && pll_resetb) check("wd_width", 32'(low_len), 32'd16);
`else
      check("pll_resetb_const", 32'(pll_resetb), 32'd1);
`endif
      prev_b = pll_resetb;
    end
`ifdef PLL_RESET_WATCHDOG_EN
    check("wd_seen", 32'(first_start >= 0), 32'd1);
`endif

    repeat (50) begin
      if (exp_q.size() != 0) @(negedge clock);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
